instr_fetch_queue: RTL and testbench

//  Instruction-fetch stage directly upstream of the opcode reader. Walks a byte-wide

---
 rtl/instr_fetch_queue_if.sv | 31 +++
 rtl/instr_fetch_queue.sv | 109 ++++++++++
 tb/tb_instr_fetch_queue.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// Bundle of the fetch-queue memory port, redirect input and opcode handshake.
// The slave modport is the fetch queue; the master modport is the memory/reader side.
interface instr_fetch_queue_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_ip;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_code;
    logic [ADDR_W-1:0] op_ip;
    logic [CNT_W-1:0]  count;

    modport slave (
        output mem_req, mem_addr, op_valid, op_code, op_ip, count,
        input  mem_ack, mem_data, redirect, redirect_ip, op_ready
    );

    modport master (
        input  mem_req, mem_addr, op_valid, op_code, op_ip, count,
        output mem_ack, mem_data, redirect, redirect_ip, op_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: walks byte memory from a fetch pointer, buffers opcodes with
// their addresses in a small FIFO and hands them out over valid/ready; redirects flush.
module instr_fetch_queue #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_IP = '0
) (
    input logic                 i_clk,
    input logic                 i_reset,
    instr_fetch_queue_if.slave  io_bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StFetch, StDiscard} state_e;

    state_e            r_state, w_state_d;
    logic [ADDR_W-1:0] r_fetch_ip, w_fetch_ip_d;
    logic [ADDR_W-1:0] r_pend_ip, w_pend_ip_d;
    logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0]  r_count, w_count_d;
    logic [DATA_W-1:0] r_code [DEPTH];
    logic [ADDR_W-1:0] r_ip   [DEPTH];

    logic w_ack, w_push, w_pop;

    always_comb begin
        w_ack        = (r_state != StIdle) && io_bus.mem_ack;
        w_push       = (r_state == StFetch) && w_ack && !io_bus.redirect;
        w_pop        = (r_count != '0) && io_bus.op_ready && !io_bus.redirect;
        w_count_d    = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_state_d    = r_state;
        w_fetch_ip_d = r_fetch_ip;
        w_pend_ip_d  = r_pend_ip;
        if (io_bus.redirect) begin
            // A request still in flight keeps its address until acked; park the target.
            if ((r_state != StIdle) && !w_ack) begin
                w_state_d   = StDiscard;
                w_pend_ip_d = io_bus.redirect_ip;
            end else begin
                w_state_d    = StFetch;
                w_fetch_ip_d = io_bus.redirect_ip;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (r_count < CNT_W'(DEPTH)) w_state_d = StFetch;
                end
                StFetch: begin
                    if (w_ack) begin
                        w_fetch_ip_d = r_fetch_ip + 1'b1;
                        w_state_d    = (w_count_d < CNT_W'(DEPTH)) ? StFetch : StIdle;
                    end
                end
                StDiscard: begin
                    if (w_ack) begin
                        w_fetch_ip_d = r_pend_ip;
                        w_state_d    = StFetch;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= StIdle;
            r_fetch_ip <= RESET_IP;
            r_pend_ip  <= RESET_IP;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_d;
            r_fetch_ip <= w_fetch_ip_d;
            r_pend_ip  <= w_pend_ip_d;
            if (io_bus.redirect) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= w_count_d;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_code[i] <= '0;
                r_ip[i]   <= '0;
            end
        end else if (w_push) begin
            r_code[r_wr_ptr] <= io_bus.mem_data;
            r_ip[r_wr_ptr]   <= r_fetch_ip;
        end
    end

    assign io_bus.mem_req  = (r_state != StIdle);
    assign io_bus.mem_addr = r_fetch_ip;
    assign io_bus.op_valid = (r_count != '0);
    assign io_bus.op_code  = r_code[r_rd_ptr];
    assign io_bus.op_ip    = r_ip[r_rd_ptr];
    assign io_bus.count    = r_count;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue; memory returns addr^8'hA5 unless overridden.
module tb_instr_fetch_queue;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic       data_ovr_en;
    logic [7:0] data_ovr;

    instr_fetch_queue_if #(.ADDR_W(8), .DATA_W(8), .DEPTH(4)) bus ();

    instr_fetch_queue #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .DEPTH   (4),
        .RESET_IP(8'h00)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .io_bus  (bus.slave)
    );

    assign bus.mem_data = data_ovr_en ? data_ovr : (bus.mem_addr ^ 8'hA5);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [7:0] ip, input logic [2:0] cnt);
        check({tag, ".valid"}, 32'(bus.op_valid), 32'(cnt != 0));
        check({tag, ".ip"}, 32'(bus.op_ip), 32'(ip));
        check({tag, ".code"}, 32'(bus.op_code), 32'(ip ^ 8'hA5));
        check({tag, ".count"}, 32'(bus.count), 32'(cnt));
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        data_ovr_en     = 1'b0;
        data_ovr        = 8'h00;
        bus.mem_ack     = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_ip = 8'h00;
        bus.op_ready    = 1'b0;
        rst_n           = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst.mem_req", 32'(bus.mem_req), 0);
        check("rst.mem_addr", 32'(bus.mem_addr), 0);
        check("rst.op_valid", 32'(bus.op_valid), 0);
        check("rst.op_code", 32'(bus.op_code), 0);
        check("rst.op_ip", 32'(bus.op_ip), 0);
        check("rst.count", 32'(bus.count), 0);

        // Fill from reset with ack tied high and reader stalled
        bus.mem_ack = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        check("fill.req1", 32'(bus.mem_req), 1);
        check("fill.valid_early", 32'(bus.op_valid), 0);
        step();
        check_head("fill.first", 8'h00, 3'd1);
        step(); step(); step();
        check_head("fill.full", 8'h00, 3'd4);
        check("fill.req_idle", 32'(bus.mem_req), 0);
        check("fill.addr", 32'(bus.mem_addr), 32'h04);
        step();
        check_head("fill.hold", 8'h00, 3'd4);

        // One pop from full, one refill at 04
        bus.op_ready = 1'b1;
        step();
        bus.op_ready = 1'b0;
        check_head("pop1", 8'h01, 3'd3);
        check("pop1.req", 32'(bus.mem_req), 0);
        step();
        check("refill.req", 32'(bus.mem_req), 1);
        check("refill.addr", 32'(bus.mem_addr), 32'h04);
        step();
        check("refill.count", 32'(bus.count), 4);
        check("refill.idle", 32'(bus.mem_req), 0);

        // Drain with memory stalled: 01,02,03,04 in order
        bus.mem_ack  = 1'b0;
        bus.op_ready = 1'b1;
        step(); check_head("drain.a", 8'h02, 3'd3);
        step(); check_head("drain.b", 8'h03, 3'd2);
        step(); check_head("drain.c", 8'h04, 3'd1);
        step();
        bus.op_ready = 1'b0;
        check("drain.empty", 32'(bus.op_valid), 0);

        // Delayed ack: request held for 3 cycles at 05
        for (int i = 0; i < 3; i++) begin
            check("slow.req", 32'(bus.mem_req), 1);
            check("slow.addr", 32'(bus.mem_addr), 32'h05);
            check("slow.valid", 32'(bus.op_valid), 0);
            step();
        end
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check_head("slow.done", 8'h05, 3'd1);
        check("slow.next", 32'(bus.mem_addr), 32'h06);

        // Redirect to 40 while request at 06 pending; squashed ack returns EE
        bus.redirect    = 1'b1;
        bus.redirect_ip = 8'h40;
        step();
        bus.redirect = 1'b0;
        check("redir.count", 32'(bus.count), 0);
        check("redir.valid", 32'(bus.op_valid), 0);
        check("redir.oldaddr", 32'(bus.mem_addr), 32'h06);
        step();
        check("redir.hold", 32'(bus.mem_addr), 32'h06);
        data_ovr_en = 1'b1;
        data_ovr    = 8'hEE;
        bus.mem_ack = 1'b1;
        step();
        data_ovr_en = 1'b0;
        check("redir.drop", 32'(bus.op_valid), 0);
        check("redir.newaddr", 32'(bus.mem_addr), 32'h40);
        check("redir.req", 32'(bus.mem_req), 1);
        step();
        check_head("redir.first", 8'h40, 3'd1);

        // Redirect to FE with ack every cycle and reader ready: FE,FF,00,01
        bus.redirect    = 1'b1;
        bus.redirect_ip = 8'hFE;
        bus.op_ready    = 1'b1;
        step();
        bus.redirect = 1'b0;
        check("wrap.flush", 32'(bus.count), 0);
        check("wrap.addr", 32'(bus.mem_addr), 32'hFE);
        step(); check_head("wrap.fe", 8'hFE, 3'd1);
        step(); check_head("wrap.ff", 8'hFF, 3'd1);
        step(); check_head("wrap.00", 8'h00, 3'd1);
        step(); check_head("wrap.01", 8'h01, 3'd1);

        // Reset mid-request with two entries held
        bus.op_ready = 1'b0;
        step();
        bus.mem_ack = 1'b0;
        check("mid.count", 32'(bus.count), 2);
        step();
        check("mid.pending", 32'(bus.mem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid.rst.req", 32'(bus.mem_req), 0);
        check("mid.rst.addr", 32'(bus.mem_addr), 0);
        check("mid.rst.count", 32'(bus.count), 0);
        check("mid.rst.valid", 32'(bus.op_valid), 0);
        check("mid.rst.code", 32'(bus.op_code), 0);
        check("mid.rst.ip", 32'(bus.op_ip), 0);
        bus.mem_ack = 1'b1;
        step();
        check("mid.rst.stale", 32'(bus.count), 0);
        rst_n = 1'b1;
        step();
        check("mid.restart.count", 32'(bus.count), 0);
        check("mid.restart.req", 32'(bus.mem_req), 1);
        check("mid.restart.addr", 32'(bus.mem_addr), 0);
        step();
        check_head("mid.restart.first", 8'h00, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
